// File: rtl/count_pwm_gen_if.sv
// -----------------------------------------------------------------------------
// count_pwm_gen_if
//   Duty-update handshake between a duty source and count_pwm_gen.
//   A transfer happens on a rising clock edge where duty_valid and duty_ready
//   are both high.
//
// Parameters
//   CW          width of the PWM count; duty values span 0..2**CW
//
// Signals
//   duty_in     [CW:0]  requested duty in high cycles per period
//   duty_valid          duty_in holds a valid request
//   duty_ready          consumer can accept a request this cycle
//
// Modports
//   master  duty source   (drives duty_in/duty_valid, sees duty_ready)
//   slave   count_pwm_gen (sees duty_in/duty_valid, drives duty_ready)
// -----------------------------------------------------------------------------
interface count_pwm_gen_if #(
  parameter int CW = 4
);
  logic [CW:0] duty_in;
  logic        duty_valid;
  logic        duty_ready;

  modport master (
    output duty_in,
    output duty_valid,
    input  duty_ready
  );

  modport slave (
    input  duty_in,
    input  duty_valid,
    output duty_ready
  );
endinterface : count_pwm_gen_if

// File: rtl/count_pwm_gen.sv
// -----------------------------------------------------------------------------
// count_pwm_gen
//   PWM generator driven by the count bus of a free-running up counter.
//   One PWM period per counter wrap; the output is high while the count is
//   below the active duty. Duty updates arrive over a valid/ready handshake,
//   are parked in a shadow register and only take effect at a wrap, so a
//   period is never cut short or stretched by an update.
//
// Parameters
//   CW          count width; period = 2**CW cycles
//   DUTY_RST    active duty after reset (0..2**CW)
//
// Ports
//   clk           in   system clock, rising edge
//   rst           in   synchronous active-high reset
//   count_in      in   [CW-1:0] count from the upstream counter
//   duty_if       slave handshake: duty_in [CW:0], duty_valid, duty_ready
//   pwm_out       out  registered PWM output
//   period_start  out  one-cycle pulse aligned with the count-0 PWM cycle
//   active_duty   out  [CW:0] duty governing the current period
//   period_cnt    out  [7:0] wrap counter, present only with the option below
//
// Build option
//   PWM_PERIOD_CNT_EN  when defined, adds period_cnt: increments on every wrap,
//                      rolls over 255 -> 0, cleared by reset.
// -----------------------------------------------------------------------------
module count_pwm_gen #(
  parameter int          CW       = 4,
  parameter int unsigned DUTY_RST = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [CW-1:0] count_in,
  count_pwm_gen_if.slave duty_if,
  output logic          pwm_out,
  output logic          period_start,
`ifdef PWM_PERIOD_CNT_EN
  output logic [CW:0]   active_duty,
  output logic [7:0]    period_cnt
`else
  output logic [CW:0]   active_duty
`endif
);

  localparam logic [CW:0] DUTY_MAX  = {1'b1, {CW{1'b0}}};
  localparam logic [CW:0] DUTY_INIT = (CW+1)'(DUTY_RST);

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic          w_accept;
  logic          w_apply;
  logic          w_wrap;
  logic [CW-1:0] r_count_q;
  logic [CW:0]   r_pend_duty;
  logic [CW:0]   r_active_duty;
  logic [CW:0]   w_duty_sat;
  logic [CW:0]   w_duty_eff;
  logic          r_duty_ready;
  logic          r_pwm;
  logic          r_period_start;

  // A count lower than last cycle's means the counter restarted, whether it
  // rolled over normally or was restarted early. Right after reset r_count_q
  // is 0, so no wrap can be seen on that first cycle.
  assign w_wrap = (count_in < r_count_q);

  // Requests above full scale saturate to "always high".
  assign w_duty_sat = (duty_if.duty_in > DUTY_MAX) ? DUTY_MAX : duty_if.duty_in;

  // On the wrap that applies a pending update, the new duty already governs
  // the count-0 cycle of the new period.
  assign w_duty_eff = (w_wrap && (r_state == PEND)) ? r_pend_duty : r_active_duty;

  // NOTE: every signal driven here gets a default before the case statement,
  // so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_apply     = 1'b0;
    unique case (r_state)
      IDLE: begin
        // A request arriving on a wrap cycle is accepted but waits for the
        // next wrap; the period starting now keeps the old duty.
        if (duty_if.duty_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = PEND;
        end
      end
      PEND: begin
        if (w_wrap) begin
          w_apply     = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= IDLE;
      r_count_q      <= '0;
      r_pend_duty    <= '0;
      r_active_duty  <= DUTY_INIT;
      r_duty_ready   <= 1'b1;
      r_pwm          <= 1'b0;
      r_period_start <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_count_q      <= count_in;
      // Ready is a registered decode of the state we are moving into.
      r_duty_ready   <= (w_state_nxt == IDLE);
      r_pwm          <= ({1'b0, count_in} < w_duty_eff);
      r_period_start <= w_wrap;
      if (w_accept) begin
        r_pend_duty <= w_duty_sat;
      end
      if (w_apply) begin
        r_active_duty <= r_pend_duty;
      end
    end
  end

`ifdef PWM_PERIOD_CNT_EN
  logic [7:0] r_period_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_period_cnt <= '0;
    end else if (w_wrap) begin
      r_period_cnt <= r_period_cnt + 8'd1;
    end
  end

  assign period_cnt = r_period_cnt;
`endif

  assign duty_if.duty_ready = r_duty_ready;
  assign pwm_out            = r_pwm;
  assign period_start       = r_period_start;
  assign active_duty        = r_active_duty;

endmodule : count_pwm_gen

// File: tb/tb_count_pwm_gen.sv
// -----------------------------------------------------------------------------
// tb_count_pwm_gen
//   Directed bench for count_pwm_gen with CW=4, DUTY_RST=0. The bench plays the
//   upstream counter (0..15 repeating) and the duty source. Inputs change 1 ns
//   after the rising edge and outputs are sampled at that same point, so each
//   sample reflects the count presented on the edge just taken.
//   Define PWM_PERIOD_CNT_EN for both bench and RTL to exercise period_cnt.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_count_pwm_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] count_in;
  logic       pwm_out;
  logic       period_start;
  logic [4:0] active_duty;
`ifdef PWM_PERIOD_CNT_EN
  logic [7:0] period_cnt;
`endif

  int checks = 0;
  int errors = 0;
  int exp_pc = 0;

  count_pwm_gen_if #(.CW(4)) duty_if ();

  count_pwm_gen #(.CW(4), .DUTY_RST(0)) dut (
    .clk          (clk),
    .rst          (rst),
    .count_in     (count_in),
    .duty_if      (duty_if),
    .pwm_out      (pwm_out),
    .period_start (period_start),
`ifdef PWM_PERIOD_CNT_EN
    .active_duty  (active_duty),
    .period_cnt   (period_cnt)
`else
    .active_duty  (active_duty)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full period with counts 0..15 presented. exp_ps0 says whether the
  // count-0 cycle is a wrap. A duty request (load_val) is offered for one
  // cycle while count load_at is presented; load_at < 0 means no request.
  task automatic period(input string tag, input int exp_duty, input logic exp_ps0,
                        input int load_at, input logic [4:0] load_val);
    int   highs   = 0;
    logic exp_rdy = 1'b1;
    for (int c = 0; c < 16; c++) begin
      count_in = 4'(c);
      if (c == load_at) begin
        duty_if.duty_valid = 1'b1;
        duty_if.duty_in    = load_val;
      end
      tick();
      duty_if.duty_valid = 1'b0;
      if (c == load_at) exp_rdy = 1'b0;
      if (c == 0 && exp_ps0) exp_pc = (exp_pc + 1) % 256;
      check({tag, " pwm"},    32'(pwm_out),      32'(c < exp_duty));
      check({tag, " pstart"}, 32'(period_start), 32'((c == 0) && exp_ps0));
      check({tag, " active"}, 32'(active_duty),  32'(exp_duty));
      check({tag, " ready"},  32'(duty_if.duty_ready), 32'(exp_rdy));
`ifdef PWM_PERIOD_CNT_EN
      check({tag, " pcnt"},   32'(period_cnt),   32'(exp_pc));
`endif
      if (pwm_out === 1'b1) highs++;
    end
    check({tag, " highs"}, 32'(highs), 32'(exp_duty));
  endtask

  task automatic do_reset();
    rst                = 1'b1;
    count_in           = 4'd0;
    duty_if.duty_valid = 1'b0;
    duty_if.duty_in    = 5'd0;
    repeat (3) tick();
    exp_pc = 0;
    check("rst pwm",    32'(pwm_out),            32'd0);
    check("rst pstart", 32'(period_start),       32'd0);
    check("rst ready",  32'(duty_if.duty_ready), 32'd1);
    check("rst active", 32'(active_duty),        32'd0);
`ifdef PWM_PERIOD_CNT_EN
    check("rst pcnt",   32'(period_cnt),         32'd0);
`endif
    rst = 1'b0;
  endtask

  initial begin
    // 1: reset, first pass without wrap, then a wrap with no duty change
    do_reset();
    period("t1 first", 0, 1'b0, -1, 5'd0);
    // 2: request 4 at count 7; applied at the next wrap
    period("t2 load",  0, 1'b1, 7, 5'd4);
    period("t2 duty4", 4, 1'b1, -1, 5'd0);
    // 3: full scale, clamped over-range, zero
    period("t3 load16", 4,  1'b1, 3, 5'd16);
    period("t3 duty16", 16, 1'b1, -1, 5'd0);
    period("t3 load20", 16, 1'b1, 5, 5'd20);
    period("t3 clamp",  16, 1'b1, -1, 5'd0);
    period("t3 load0",  16, 1'b1, 2, 5'd0);
    period("t3 duty0",  0,  1'b1, -1, 5'd0);
    // 4: request on the wrap cycle while idle waits one period
    period("t4 load4", 0, 1'b1, 9, 5'd4);
    period("t4 duty4", 4, 1'b1, -1, 5'd0);
    period("t4 wrapld", 4, 1'b1, 0, 5'd8);
    period("t4 duty8", 8, 1'b1, -1, 5'd0);

    // 5: accept 10, then reset at count 9 before the wrap
    for (int c = 0; c < 9; c++) begin
      count_in = 4'(c);
      if (c == 0) exp_pc = (exp_pc + 1) % 256;
      if (c == 4) begin
        duty_if.duty_valid = 1'b1;
        duty_if.duty_in    = 5'd10;
      end
      tick();
      duty_if.duty_valid = 1'b0;
      check("t5 pwm", 32'(pwm_out), 32'(c < 8));
    end
    check("t5 ready pend", 32'(duty_if.duty_ready), 32'd0);
    count_in = 4'd9;
    rst      = 1'b1;
    tick();
    exp_pc = 0;
    check("t5 rst pwm",    32'(pwm_out),            32'd0);
    check("t5 rst active", 32'(active_duty),        32'd0);
    check("t5 rst ready",  32'(duty_if.duty_ready), 32'd1);
    rst = 1'b0;
    for (int c = 10; c < 16; c++) begin
      count_in = 4'(c);
      tick();
      check("t5 tail pwm",    32'(pwm_out),      32'd0);
      check("t5 tail pstart", 32'(period_start), 32'd0);
      check("t5 tail active", 32'(active_duty),  32'd0);
    end
    period("t5 after", 0, 1'b1, -1, 5'd0);

`ifdef PWM_PERIOD_CNT_EN
    // 6: period counter after reset, then rollover
    do_reset();
    period("t6 p0", 0, 1'b0, -1, 5'd0);
    period("t6 p1", 0, 1'b1, -1, 5'd0);
    period("t6 p2", 0, 1'b1, -1, 5'd0);
    period("t6 p3", 0, 1'b1, -1, 5'd0);
    check("t6 pcnt3", 32'(period_cnt), 32'd3);
    // Alternate 0/1 so every 0 is a wrap; 252 more wraps reach 255.
    for (int w = 0; w < 252; w++) begin
      count_in = 4'd0;
      tick();
      count_in = 4'd1;
      tick();
    end
    check("t6 pcnt255", 32'(period_cnt), 32'd255);
    count_in = 4'd0;
    tick();
    check("t6 pcnt roll", 32'(period_cnt), 32'd0);
    check("t6 roll pstart", 32'(period_start), 32'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_count_pwm_gen
